// File: rtl/dfd_tn_gnt_sched.sv
// dfd_tn_gnt_sched
// This block shares one trace-network link among NUM_PORTS interfaces. It
// uses weighted round-robin to pick the port, and it only grants while the
// downstream buffer has credits.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no grants; wait for enable or a flush request
// ARB   | weighted round-robin grants, gated by credits
// DRAIN | no grants; wait for all credits back and the link to go empty
// DONE  | flush_done_out pulses for one cycle, then back to IDLE
//
// Ports:
//   clock, reset            : the only clock; synchronous active-high reset
//   cfg_enable_in           : scheduler enable
//   cfg_weight_in           : weight field per port (0 acts as 1)
//   port_req_in             : the port has a beat ready to pull
//   port_gnt_out            : registered one-hot grant
//   port_valid_in/src/data  : the granted interface pulls in the grant cycle
//   link_*_out              : the beat, registered one cycle after its pull
//   link_credit_return_in   : one downstream credit comes back per cycle
//   flush_req_in            : level request to stop and drain
//   flush_done_out          : one-cycle pulse once the drain is complete
//   credit_cnt_out          : credits currently available
//   err_credit_ovf_out      : sticky flag; a credit came back while the
//                             counter was already full
module dfd_tn_gnt_sched #(
  parameter int NUM_PORTS           = 4,
  parameter int DATA_WIDTH_IN_BYTES = 16,
  parameter int CREDITS             = 8,
  parameter int WEIGHT_W            = 4
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   cfg_enable_in,
  input  logic [NUM_PORTS*WEIGHT_W-1:0]          cfg_weight_in,
  input  logic [NUM_PORTS-1:0]                   port_req_in,
  output logic [NUM_PORTS-1:0]                   port_gnt_out,
  input  logic [NUM_PORTS-1:0]                   port_valid_in,
  input  logic [NUM_PORTS-1:0]                   port_src_in,
  input  logic [NUM_PORTS*DATA_WIDTH_IN_BYTES*8-1:0] port_data_in,
  output logic                                   link_valid_out,
  output logic                                   link_src_out,
  output logic [$clog2(NUM_PORTS)-1:0]           link_port_out,
  output logic [DATA_WIDTH_IN_BYTES*8-1:0]       link_data_out,
  input  logic                                   link_credit_return_in,
  input  logic                                   flush_req_in,
  output logic                                   flush_done_out,
  output logic [$clog2(CREDITS+1)-1:0]           credit_cnt_out,
  output logic                                   err_credit_ovf_out
);

  localparam int DW  = DATA_WIDTH_IN_BYTES * 8;
  localparam int PW  = $clog2(NUM_PORTS);
  localparam int CW  = $clog2(CREDITS + 1);
  localparam int CW1 = CW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ARB   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state, state_d;
  logic [NUM_PORTS-1:0] gnt, gnt_d;
  logic [PW-1:0]        ptr, ptr_d, nxt;
  logic [WEIGHT_W-1:0]  beat, beat_d, owner_w, eff_w;
  logic [CW-1:0]        cnt, cnt_d;
  logic [CW1-1:0]       avail, sum;
  logic                 refund, found, keep, arb_ok, issue, ovf;
  logic                 cap_valid, cap_src;
  logic [PW-1:0]        cap_port;
  logic [DW-1:0]        cap_data;
  logic                 link_valid, link_src;
  logic [PW-1:0]        link_port;
  logic [DW-1:0]        link_data;
  logic                 err;

  // Capture the pulled beat. The grant is one-hot, so at most one port matches.
  always_comb begin
    cap_valid = 1'b0;
    cap_src   = 1'b0;
    cap_port  = '0;
    cap_data  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p] && port_valid_in[p]) begin
        cap_valid = 1'b1;
        cap_src   = port_src_in[p];
        cap_port  = PW'(p);
        cap_data  = port_data_in[p*DW +: DW];
      end
    end
  end

  // A grant whose port did not pull returns its credit on this edge.
  assign refund = |(gnt & ~port_valid_in);
  assign avail  = {1'b0, cnt} + CW1'(refund) + CW1'(link_credit_return_in);

  // Weighted round-robin. beat counts the grants the owner has had in its
  // current tenure. The search starts at owner+1 and wraps around, so a lone
  // requester comes back to itself.
  always_comb begin
    owner_w = cfg_weight_in[int'(ptr)*WEIGHT_W +: WEIGHT_W];
    eff_w   = (owner_w == '0) ? WEIGHT_W'(1) : owner_w;
    keep    = port_req_in[ptr] && (beat < eff_w);

    found = 1'b0;
    nxt   = ptr;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      if (!found && port_req_in[(int'(ptr) + i) % NUM_PORTS]) begin
        found = 1'b1;
        nxt   = PW'((int'(ptr) + i) % NUM_PORTS);
      end
    end

    arb_ok = (state == ARB) && cfg_enable_in && !flush_req_in && (avail != '0);
    gnt_d  = '0;
    ptr_d  = ptr;
    beat_d = beat;
    if (arb_ok) begin
      if (keep) begin
        gnt_d[ptr] = 1'b1;
        beat_d     = beat + WEIGHT_W'(1);
      end else if (found) begin
        gnt_d[nxt] = 1'b1;
        ptr_d      = nxt;
        beat_d     = WEIGHT_W'(1);
      end else if (!port_req_in[ptr]) begin
        beat_d = '0;
      end
    end
  end

  // Reserve one credit for each new grant. The only way to go above full is
  // a return while the counter is full and nothing is being reserved. That
  // return is dropped and recorded as an error.
  always_comb begin
    issue = |gnt_d;
    sum   = avail - CW1'(issue);
    ovf   = 1'b0;
    cnt_d = sum[CW-1:0];
    if (sum > CW1'(CREDITS)) begin
      cnt_d = CW'(CREDITS);
      ovf   = 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:  if (flush_req_in) state_d = DRAIN;
             else if (cfg_enable_in) state_d = ARB;
      ARB:   if (flush_req_in) state_d = DRAIN;
             else if (!cfg_enable_in) state_d = IDLE;
      DRAIN: if ((cnt == CW'(CREDITS)) && !link_valid) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= '0;
      ptr        <= '0;
      beat       <= '0;
      cnt        <= CW'(CREDITS);
      err        <= 1'b0;
      link_valid <= 1'b0;
      link_src   <= 1'b0;
      link_port  <= '0;
      link_data  <= '0;
    end else begin
      state      <= state_d;
      gnt        <= gnt_d;
      ptr        <= ptr_d;
      beat       <= beat_d;
      cnt        <= cnt_d;
      err        <= err | ovf;
      link_valid <= cap_valid;
      if (cap_valid) begin
        link_src  <= cap_src;
        link_port <= cap_port;
        link_data <= cap_data;
      end
    end
  end

  assign port_gnt_out       = gnt;
  assign link_valid_out     = link_valid;
  assign link_src_out       = link_src;
  assign link_port_out      = link_port;
  assign link_data_out      = link_data;
  assign credit_cnt_out     = cnt;
  assign err_credit_ovf_out = err;
  assign flush_done_out     = (state == DONE);

endmodule
